// File: rtl/udma_eth_tx_scheduler.sv
// Descriptor-queue scheduler that feeds udma_eth_tx_controller one frame at a time.
// Optional inter-frame gap support is compiled in with `define UDMA_ETH_TX_IFG_EN.
module udma_eth_tx_scheduler #(
   parameter int L2_AWIDTH_NOAL = 12,
   parameter int TRANS_SIZE     = 16,
   parameter int DESC_DEPTH     = 4
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [L2_AWIDTH_NOAL-1:0]     desc_addr_i,
   input  logic [TRANS_SIZE-1:0]         desc_size_i,
   input  logic                          desc_push_i,
   output logic                          desc_full_o,
   output logic [$clog2(DESC_DEPTH):0]   desc_count_o,
   input  logic                          sched_en_i,
   input  logic                          sched_clr_i,
`ifdef UDMA_ETH_TX_IFG_EN
   input  logic [7:0]                    ifg_cycles_i,
`endif
   output logic [L2_AWIDTH_NOAL-1:0]     ctl_tx_startaddr_o,
   output logic [TRANS_SIZE-1:0]         ctl_tx_size_o,
   output logic                          ctl_tx_en_o,
   input  logic                          ctl_frame_done_i,
   output logic                          frame_evt_o,
   output logic [15:0]                   frames_sent_o,
   output logic                          idle_o,
   output logic                          err_zero_o,
   output logic                          err_ovf_o
);

   localparam int PTR_W = $clog2(DESC_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

   state_t                    state;
   logic [L2_AWIDTH_NOAL-1:0] addr_mem [DESC_DEPTH];
   logic [TRANS_SIZE-1:0]     size_mem [DESC_DEPTH];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic                      full;
   logic                      empty;
   logic                      size_zero;
   logic                      push_ok;
   logic                      pop;
   logic                      done;
`ifdef UDMA_ETH_TX_IFG_EN
   logic [7:0]                gap_cnt;
`endif

   assign full      = (desc_count_o == CNT_W'(DESC_DEPTH));
   assign empty     = (desc_count_o == '0);
   assign size_zero = (desc_size_i == '0);
   assign push_ok   = desc_push_i & ~sched_clr_i & ~full & ~size_zero;
   assign pop       = (state == ISSUE) & ~sched_clr_i;
   assign done      = (state == WAIT_DONE) & ctl_frame_done_i;

   assign desc_full_o = full;
   assign idle_o      = (state == IDLE) & empty;
   // A clear landing in ISSUE suppresses the start pulse in that same cycle.
   assign ctl_tx_en_o = (state == ISSUE) & ~sched_clr_i;

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         addr_mem[wr_ptr] <= desc_addr_i;
         size_mem[wr_ptr] <= desc_size_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         desc_count_o <= '0;
         err_zero_o   <= 1'b0;
         err_ovf_o    <= 1'b0;
      end else if (sched_clr_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         desc_count_o <= '0;
         err_zero_o   <= 1'b0;
         err_ovf_o    <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   desc_count_o <= desc_count_o + CNT_W'(1);
            2'b01:   desc_count_o <= desc_count_o - CNT_W'(1);
            default: desc_count_o <= desc_count_o;
         endcase
         // Full is judged on pre-pop occupancy, so a same-cycle pop does not rescue the push.
         if (desc_push_i && full)
            err_ovf_o <= 1'b1;
         if (desc_push_i && size_zero)
            err_zero_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         frames_sent_o <= '0;
      end else if (sched_clr_i) begin
         frames_sent_o <= '0;
      end else if (done) begin
         frames_sent_o <= frames_sent_o + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state              <= IDLE;
         ctl_tx_startaddr_o <= '0;
         ctl_tx_size_o      <= '0;
         frame_evt_o        <= 1'b0;
`ifdef UDMA_ETH_TX_IFG_EN
         gap_cnt            <= '0;
`endif
      end else begin
         frame_evt_o <= 1'b0;
         case (state)
            IDLE: begin
               if (sched_en_i && !empty && !sched_clr_i) begin
                  state              <= ISSUE;
                  ctl_tx_startaddr_o <= addr_mem[rd_ptr];
                  ctl_tx_size_o      <= size_mem[rd_ptr];
               end
            end
            ISSUE: begin
               state <= sched_clr_i ? IDLE : WAIT_DONE;
            end
            WAIT_DONE: begin
               // Frames cannot be aborted, so only completion leaves this state.
               if (ctl_frame_done_i) begin
                  frame_evt_o <= 1'b1;
`ifdef UDMA_ETH_TX_IFG_EN
                  if (ifg_cycles_i != 8'd0) begin
                     state   <= GAP;
                     gap_cnt <= ifg_cycles_i;
                  end else begin
                     state   <= IDLE;
                  end
`else
                  state <= IDLE;
`endif
               end
            end
            GAP: begin
`ifdef UDMA_ETH_TX_IFG_EN
               if (sched_clr_i || gap_cnt <= 8'd1) begin
                  state   <= IDLE;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
`else
               state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
